sck_burst_ctrl: RTL

//  Sequencer for the DDR output-clock pad: emits the 2-bit per-cycle word for
//  the SB_IO DDR clock pin so that a serial-flash/SPI SCK produces exactly N

---
 rtl/sck_pkg.sv | 13 +
 rtl/sck_halfcnt.sv | 21 ++
 rtl/sck_burst_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/sck_pkg.sv
// sck_pkg: shared state encoding, DDR word constants and width defaults for the SCK sequencer
package sck_pkg;
  localparam int DEF_LGCOUNT = 8;
  localparam int DEF_LGDIV = 4;
  typedef enum logic {IDLE, RUN} state_t;
  // Words are written relative to cpol=0 and xor'ed with the idle level.
  localparam logic [1:0] W_IDLE = 2'b00;
  localparam logic [1:0] W_FULL = 2'b10;
  localparam logic [1:0] W_HIGH = 2'b11;
  function automatic logic [1:0] ddr_word(input logic [1:0] w, input logic cpol);
    return w ^ {2{cpol}};
  endfunction
endpackage

// File: rtl/sck_halfcnt.sv
// sck_halfcnt: reload counter timing one SCK half-period in i_clk cycles
//  i_clk, i_reset_n : clock, async active-low reset
//  i_load           : restart a half-period of i_div cycles
//  i_div            : half-period length; 0 bypasses the counter
//  o_tick           : current cycle is the last of the half-period
module sck_halfcnt import sck_pkg::*; #(
  parameter int LGDIV = DEF_LGDIV
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [LGDIV-1:0] i_div,
  output logic             o_tick
);
  logic [LGDIV-1:0] cnt;
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) cnt <= '0;
    else if (i_load) cnt <= i_div - LGDIV'(1);
    else if (cnt != '0) cnt <= cnt - LGDIV'(1);
  assign o_tick = (i_div == '0) || (cnt == '0);
endmodule

// File: rtl/sck_burst_ctrl.sv
// sck_burst_ctrl: sequences the 2-bit DDR SCK pad word for N-period bursts with edge strobes
//  i_clk, i_reset_n           : clock (also pad DDR clock), async active-low reset
//  i_cfg_wr/i_cfg_cpol/i_cfg_div : idle-time config of idle level and half-period divider
//  i_stb, i_cycles            : start a burst of i_cycles SCK periods when idle
//  o_busy, o_done             : burst in progress, one-cycle completion pulse
//  o_ddr                      : [1] first-half level, [0] second-half level
//  o_lead, o_trail            : word contains a leading / trailing SCK edge
module sck_burst_ctrl import sck_pkg::*; #(
  parameter int               LGCOUNT     = DEF_LGCOUNT,
  parameter int               LGDIV       = DEF_LGDIV,
  parameter logic [LGDIV-1:0] DEFAULT_DIV = '0
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cfg_wr,
  input  logic               i_cfg_cpol,
  input  logic [LGDIV-1:0]   i_cfg_div,
  input  logic               i_stb,
  input  logic [LGCOUNT-1:0] i_cycles,
  output logic               o_busy,
  output logic [1:0]         o_ddr,
  output logic               o_lead,
  output logic               o_trail,
  output logic               o_done
);
  state_t state, state_n;
  logic cpol, cpol_n, phase, phase_n, hc_load, hc_tick;
  logic [LGDIV-1:0] div, div_n;
  logic [LGCOUNT-1:0] cnt, cnt_n;
  logic [1:0] ddr_n;
  logic lead_n, trail_n, done_n;
  sck_halfcnt #(.LGDIV(LGDIV)) u_halfcnt (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_load(hc_load), .i_div(div_n), .o_tick(hc_tick)
  );
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      cpol <= 1'b0;
      div <= DEFAULT_DIV;
      cnt <= '0;
      phase <= 1'b0;
      o_ddr <= W_IDLE;
      o_lead <= 1'b0;
      o_trail <= 1'b0;
      o_done <= 1'b0;
    end else begin
      state <= state_n;
      cpol <= cpol_n;
      div <= div_n;
      cnt <= cnt_n;
      phase <= phase_n;
      o_ddr <= ddr_n;
      o_lead <= lead_n;
      o_trail <= trail_n;
      o_done <= done_n;
    end
  // cnt holds the periods left including the one on the pad; phase 0 = active half.
  always_comb begin
    state_n = state;
    cpol_n = cpol;
    div_n = div;
    cnt_n = cnt;
    phase_n = phase;
    ddr_n = ddr_word(W_IDLE, cpol);
    lead_n = 1'b0;
    trail_n = 1'b0;
    done_n = 1'b0;
    hc_load = 1'b0;
    if (state == IDLE) begin
      cpol_n = i_cfg_wr ? i_cfg_cpol : cpol;
      div_n = i_cfg_wr ? i_cfg_div : div;
      ddr_n = ddr_word(W_IDLE, cpol_n);
      if (i_stb && i_cycles == '0) done_n = 1'b1;
      else if (i_stb) begin
        state_n = RUN;
        cnt_n = i_cycles;
        phase_n = 1'b0;
        hc_load = 1'b1;
        ddr_n = ddr_word(div_n == '0 ? W_FULL : W_HIGH, cpol_n);
        lead_n = 1'b1;
        trail_n = div_n == '0;
      end
    end else if (!hc_tick) ddr_n = o_ddr;
    else if (div != '0 && !phase) begin
      phase_n = 1'b1;
      hc_load = 1'b1;
      trail_n = 1'b1;
    end else if (cnt == LGCOUNT'(1)) begin
      state_n = IDLE;
      done_n = 1'b1;
    end else begin
      cnt_n = cnt - LGCOUNT'(1);
      phase_n = 1'b0;
      hc_load = 1'b1;
      ddr_n = ddr_word(div == '0 ? W_FULL : W_HIGH, cpol);
      lead_n = 1'b1;
      trail_n = div == '0;
    end
  end
  assign o_busy = state == RUN;
endmodule
